// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: TX state encodings, status/control bit positions
// and register addresses used by the register block and the TX/RX engines.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Status register bit positions
    localparam int STAT_TX_BUSY_BIT = 0;
    localparam int STAT_TX_DONE_BIT = 1;

    // Control register field offsets
    localparam int CTRL_DIV_LSB        = 0;
    localparam int CTRL_DIV_MSB        = 15;
    localparam int CTRL_PARITY_EN_BIT  = 16;
    localparam int CTRL_PARITY_ODD_BIT = 17;
    localparam int CTRL_STOP2_BIT      = 18;

    // Register block address map
    localparam logic [3:0] ADDR_STAT = 4'h0;
    localparam logic [3:0] ADDR_CTRL = 4'h4;
    localparam logic [3:0] ADDR_TX   = 4'h8;
    localparam logic [3:0] ADDR_RX   = 4'hC;

    // Parity bit for a frame: even parity when odd_sel is 0.
    function automatic logic calc_parity(input logic data_xor, input logic odd_sel);
        return data_xor ^ odd_sel;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable bit-period counter: o_tick marks the last clock of each bit period,
// which is (div + 1) clocks long. Shared by the TX and RX engines.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 i_load,
    input  logic                 i_en,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;

    // Counts down from the latched divisor and reloads on zero, so it never wraps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_div <= i_div;
            r_cnt <= i_div;
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_cnt <= r_div;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_tick = i_en & (r_cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: latches one byte plus frame format on start and
// serialises start, data (LSB first), optional parity and 1-2 stop bits.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_start_i,
    input  logic [DIV_WIDTH-1:0] baud_div_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    input  logic                 stop2_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 tx_ack_o,
    output logic                 done_o
);

    localparam int BIT_CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_BITS - 1);

    tx_state_t              r_state;
    tx_state_t              w_state_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [BIT_CNT_W-1:0]   w_bit_cnt_next;
    logic                   r_tx;
    logic                   w_tx_next;
    logic                   r_busy;
    logic                   w_busy_next;
    logic                   r_ack;
    logic                   w_ack_next;
    logic                   r_done;
    logic                   w_done_next;
    logic                   r_parity_en;
    logic                   r_parity;
    logic                   r_stop2;
    logic                   w_load;
    logic                   w_tick;

    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_load (w_load),
        .i_en   (r_state != ST_IDLE),
        .i_div  (baud_div_i),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_tx_next      = r_tx;
        w_busy_next    = r_busy;
        w_ack_next     = 1'b0;
        w_done_next    = 1'b0;
        w_load         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
                // The done cycle still reads as idle but must not accept a start.
                if (tx_start_i && !r_done) begin
                    w_load         = 1'b1;
                    w_state_next   = ST_START;
                    w_shift_next   = tx_data_i;
                    w_bit_cnt_next = '0;
                    w_tx_next      = 1'b0;
                    w_busy_next    = 1'b1;
                    w_ack_next     = 1'b1;
                end
            end

            ST_START: begin
                if (w_tick) begin
                    w_state_next   = ST_DATA;
                    w_tx_next      = r_shift[0];
                    w_shift_next   = r_shift >> 1;
                    w_bit_cnt_next = '0;
                end
            end

            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == LAST_DATA_BIT) begin
                        w_bit_cnt_next = '0;
                        if (r_parity_en) begin
                            w_state_next = ST_PARITY;
                            w_tx_next    = r_parity;
                        end else begin
                            w_state_next = ST_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_tx_next      = r_shift[0];
                        w_shift_next   = r_shift >> 1;
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                if (w_tick) begin
                    w_state_next   = ST_STOP;
                    w_tx_next      = 1'b1;
                    w_bit_cnt_next = '0;
                end
            end

            ST_STOP: begin
                w_tx_next = 1'b1;
                if (w_tick) begin
                    if (r_stop2 && (r_bit_cnt == '0)) begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end else begin
                        w_state_next   = ST_IDLE;
                        w_bit_cnt_next = '0;
                        w_busy_next    = 1'b0;
                        w_done_next    = 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_ack       <= 1'b0;
            r_done      <= 1'b0;
            r_parity_en <= 1'b0;
            r_parity    <= 1'b0;
            r_stop2     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tx      <= w_tx_next;
            r_busy    <= w_busy_next;
            r_ack     <= w_ack_next;
            r_done    <= w_done_next;
            if (w_load) begin
                r_parity_en <= parity_en_i;
                r_parity    <= calc_parity(^tx_data_i, parity_odd_i);
                r_stop2     <= stop2_i;
            end
        end
    end

    assign tx_o     = r_tx;
    assign busy_o   = r_busy;
    assign tx_ack_o = r_ack;
    assign done_o   = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues hand-computed frames, a
// negedge monitor pops one per tx_ack_o and checks every output cycle by cycle.
module tb_uart_tx;

    logic        clk;
    logic        rst;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic        tx;
    logic        busy;
    logic        tx_ack;
    logic        done;

    uart_tx #(
        .DATA_BITS (8),
        .DIV_WIDTH (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tx_data_i    (tx_data),
        .tx_start_i   (tx_start),
        .baud_div_i   (baud_div),
        .parity_en_i  (parity_en),
        .parity_odd_i (parity_odd),
        .stop2_i      (stop2),
        .tx_o         (tx),
        .busy_o       (busy),
        .tx_ack_o     (tx_ack),
        .done_o       (done)
    );

    typedef struct {
        int         ack_cyc;
        int         div;
        int         nbits;
        logic [15:0] bits;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    logic rst_at_edge = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;
    logic in_frame = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle k is the one following the k-th rising edge minus one; the
    // reset value seen by the DUT at each edge is captured for the monitor.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rst_at_edge = rst;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc + 1);
        end
    endtask

    // Bit string in transmission order, first character sent first.
    function automatic logic [15:0] seq_bits(input string s);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) begin
            r[i] = (s[i] == 8'h31);
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int ack, input logic [7:0] d, input int div, input string s);
        exp_t e;
        e.ack_cyc = ack;
        e.div     = div;
        e.nbits   = s.len();
        e.bits    = seq_bits(s);
        e.data    = d;
        exp_q.push_back(e);
    endtask

    task automatic start_frame(input logic [7:0] d, input int div, input logic pen,
                               input logic podd, input logic st2, input string s,
                               input logic hold, output int ack);
        @(negedge clk);
        tx_data    = d;
        baud_div   = 16'(div);
        parity_en  = pen;
        parity_odd = podd;
        stop2      = st2;
        tx_start   = 1'b1;
        ack        = cyc + 2;
        push_exp(ack, d, div, s);
        @(negedge clk);
        if (!hold) tx_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input int div, input logic pen,
                        input logic podd, input logic st2, input string s);
        int ack;
        start_frame(d, div, pen, podd, st2, s, 1'b0, ack);
        idle(s.len() * (div + 1) + 2);
    endtask

    // Monitor: one tuple check {tx, busy, ack, done} per cycle.
    initial begin
        exp_t cur_exp;
        int   cur;
        int   off;
        int   total;
        logic e_tx, e_busy, e_ack, e_done;
        cur_exp = '{0, 0, 0, 16'h0, 8'h0};
        forever begin
            @(negedge clk);
            cur = cyc + 1;
            if (rst_at_edge && in_frame) begin
                $display("frame data=%02h abandoned by reset at cycle %0d", cur_exp.data, cur);
                in_frame = 1'b0;
            end
            e_tx = 1'b1; e_busy = 1'b0; e_ack = 1'b0; e_done = 1'b0;
            if (!in_frame && tx_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(tx_ack), 32'd0);
                end else begin
                    cur_exp = exp_q.pop_front();
                    check("ack_cycle", 32'(cur), 32'(cur_exp.ack_cyc));
                    cur_exp.ack_cyc = cur;
                    in_frame = 1'b1;
                end
            end
            if (in_frame) begin
                off   = cur - cur_exp.ack_cyc;
                total = cur_exp.nbits * (cur_exp.div + 1);
                if (off < total) begin
                    e_tx   = cur_exp.bits[off / (cur_exp.div + 1)];
                    e_busy = 1'b1;
                    e_ack  = (off == 0);
                end else begin
                    e_done   = 1'b1;
                    in_frame = 1'b0;
                    $display("frame data=%02h div=%0d acked cycle %0d done cycle %0d",
                             cur_exp.data, cur_exp.div, cur_exp.ack_cyc, cur);
                end
            end
            check("tx_busy_ack_done", {28'd0, tx, busy, tx_ack, done},
                  {28'd0, e_tx, e_busy, e_ack, e_done});
        end
    end

    initial begin
        int a;
        rst        = 1'b1;
        tx_start   = 1'b0;
        tx_data    = 8'h00;
        baud_div   = 16'd0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Basic frames
        send(8'h55, 3, 1'b0, 1'b0, 1'b0, "0101010101");
        send(8'h07, 0, 1'b1, 1'b0, 1'b0, "01110000011");
        send(8'h00, 1, 1'b1, 1'b1, 1'b1, "000000000111");

        // Start held high: second frame only after the done cycle; inputs
        // changed mid-frame must not disturb the frame in flight.
        start_frame(8'hA5, 2, 1'b0, 1'b0, 1'b0, "0101001011", 1'b1, a);
        push_exp(a + 30 + 2, 8'h3C, 2, "0001111001");
        idle(9);
        tx_data  = 8'h3C;
        baud_div = 16'd9;
        idle(10);
        baud_div = 16'd2;
        idle(20);
        tx_start = 1'b0;
        idle(35);

        // Reset during data bit 3, then reset colliding with start
        start_frame(8'h96, 1, 1'b0, 1'b0, 1'b0, "0011010011", 1'b0, a);
        idle(8);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(3);
        @(negedge clk);
        rst      = 1'b1;
        tx_start = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        rst      = 1'b0;
        tx_start = 1'b0;
        idle(3);
        send(8'hC3, 1, 1'b1, 1'b0, 1'b0, "01100001101");

        // Maximum divisor: start bit must stay low with no counter wrap
        start_frame(8'h01, 65535, 1'b0, 1'b0, 1'b0, "0100000001", 1'b0, a);
        idle(30000);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(3);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("frame_closed", 32'(in_frame), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
